// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: control-field bit positions,
// field widths and the access FSM encoding.
package mem_stage_pkg;

    localparam int WB_W  = 2;
    localparam int M_W   = 2;
    localparam int REG_W = 5;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // MemRead together with MemWrite counts as a store, so only a pure read loads.
    function automatic logic is_load(input logic [M_W-1:0] m);
        return m[M_MEMREAD] & ~m[M_MEMWRITE];
    endfunction

    function automatic logic is_store(input logic [M_W-1:0] m);
        return m[M_MEMWRITE];
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM; a read returns the contents from before
// the edge. No reset on the array or the read register.
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with LAT-cycle latency, MEM/WB
// register, and an upstream stall while a multi-cycle access is in flight.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WB_W-1:0]   WBin,
    input  logic [M_W-1:0]    Min,
    input  logic [31:0]       ALUin,
    input  logic [31:0]       WDin,
    input  logic [REG_W-1:0]  Rdin,
    output logic [WB_W-1:0]   WBout,
    output logic [31:0]       MDout,
    output logic [31:0]       ALUout,
    output logic [REG_W-1:0]  Rdout,
    output logic              stall
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [WB_W-1:0]    cap_wb_q;
    logic [M_W-1:0]     cap_m_q;
    logic [31:0]        cap_alu_q;
    logic [31:0]        cap_wd_q;
    logic [REG_W-1:0]   cap_rd_q;

    logic [WB_W-1:0]    wb_q;
    logic [31:0]        alu_q;
    logic [REG_W-1:0]   rd_q;
    logic               ld_q;

    logic               in_mem_op;
    logic               access;
    logic [M_W-1:0]     sel_m;
    logic [ADDR_W-1:0]  sel_idx;
    logic [31:0]        sel_wd;
    logic               mem_we;
    logic               mem_re;
    logic [31:0]        ram_rdata;

    assign in_mem_op = |Min;
    assign access    = (state_q == BUSY) ? (cnt_q == 4'd1)
                                         : (in_mem_op && (LAT == 1));
    assign sel_m     = (state_q == BUSY) ? cap_m_q : Min;
    assign sel_idx   = (state_q == BUSY) ? cap_alu_q[ADDR_W+1:2] : ALUin[ADDR_W+1:2];
    assign sel_wd    = (state_q == BUSY) ? cap_wd_q : WDin;

    // Gate with rst so no edge seen during reset can commit a store.
    assign mem_we = ~rst & access & is_store(sel_m);
    assign mem_re = ~rst & access & is_load(sel_m);

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (sel_idx),
        .wdata_i (sel_wd),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_wb_q  <= '0;
            cap_m_q   <= '0;
            cap_alu_q <= '0;
            cap_wd_q  <= '0;
            cap_rd_q  <= '0;
            wb_q      <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
            ld_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            if (in_mem_op && (LAT > 1)) begin
                state_q   <= BUSY;
                cnt_q     <= CNT_INIT;
                cap_wb_q  <= WBin;
                cap_m_q   <= Min;
                cap_alu_q <= ALUin;
                cap_wd_q  <= WDin;
                cap_rd_q  <= Rdin;
                wb_q      <= '0;
                alu_q     <= '0;
                rd_q      <= '0;
                ld_q      <= 1'b0;
            end else begin
                wb_q  <= WBin;
                alu_q <= ALUin;
                rd_q  <= Rdin;
                ld_q  <= is_load(Min);
            end
        end else begin
            if (cnt_q > 4'd1) begin
                cnt_q <= cnt_q - 4'd1;
                wb_q  <= '0;
                alu_q <= '0;
                rd_q  <= '0;
                ld_q  <= 1'b0;
            end else begin
                state_q <= IDLE;
                cnt_q   <= '0;
                wb_q    <= cap_wb_q;
                alu_q   <= cap_alu_q;
                rd_q    <= cap_rd_q;
                ld_q    <= is_load(cap_m_q);
            end
        end
    end

    // Load data lives in the RAM read register; ld_q selects it into MEM/WB.
    assign MDout  = ld_q ? ram_rdata : 32'h0;
    assign WBout  = wb_q;
    assign ALUout = alu_q;
    assign Rdout  = rd_q;
    assign stall  = (state_q == BUSY);

endmodule
